// File: rtl/bitmap_writer_4bit.sv
// 4-bit sprite bitmap writer: RGB332 stream encoder, 32x32 code RAM,
// bulk transparent clear and a registered read port for the drawer.
module bitmap_writer_4bit #(
    parameter int         OBJECT_WIDTH_X       = 32,
    parameter int         OBJECT_HEIGHT_Y      = 32,
    parameter logic [3:0] TRANSPARENT_ENCODING = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startLoad,
    input  logic        clearReq,
    input  logic        pixelValid,
    input  logic [7:0]  pixelRGB,
    input  logic        pixelTransparent,
    output logic        pixelReady,
    output logic        busy,
    output logic        loadDone,
    input  logic        readEnable,
    input  logic [10:0] readX,
    input  logic [10:0] readY,
    output logic [3:0]  readColor4
);

    localparam int XW    = $clog2(OBJECT_WIDTH_X);
    localparam int YW    = $clog2(OBJECT_HEIGHT_Y);
    localparam int DEPTH = OBJECT_WIDTH_X * OBJECT_HEIGHT_Y;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [3:0]      r_mem [DEPTH];

    logic [3:0]      w_enc;
    logic [3:0]      w_wdata;
    logic            w_we;
    logic            w_x_end;
    logic            w_last;
    logic            w_rd_hit;
    logic            w_unused_rgb;

    assign w_unused_rgb = ^{pixelRGB[5], pixelRGB[3], pixelRGB[2], pixelRGB[0]};

    // An opaque pixel that happens to encode as transparent is nudged to 4'hE
    always_comb begin
        w_enc = {pixelRGB[7], pixelRGB[6], pixelRGB[4], pixelRGB[1]};
        if (pixelTransparent)
            w_enc = TRANSPARENT_ENCODING;
        else if (w_enc == TRANSPARENT_ENCODING)
            w_enc = 4'hE;
    end

    assign pixelReady = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign loadDone   = (r_state == S_DONE);

    assign w_we    = (r_state == S_CLEAR) || ((r_state == S_LOAD) && pixelValid);
    assign w_wdata = (r_state == S_CLEAR) ? TRANSPARENT_ENCODING : w_enc;
    assign w_x_end = (r_x == XW'(OBJECT_WIDTH_X - 1));
    assign w_last  = w_x_end && (r_y == YW'(OBJECT_HEIGHT_Y - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (clearReq) begin
                        r_state <= S_CLEAR;
                        r_x     <= '0;
                        r_y     <= '0;
                    end else if (startLoad) begin
                        r_state <= S_LOAD;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                S_LOAD, S_CLEAR: begin
                    if (w_we) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else if (!w_x_end) begin
                            r_x <= r_x + 1'b1;
                        end else begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM has no reset so contents survive an aborted load
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[{r_y, r_x}] <= w_wdata;
    end

    assign w_rd_hit = readEnable
                   && (readX < 11'(OBJECT_WIDTH_X))
                   && (readY < 11'(OBJECT_HEIGHT_Y));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readColor4 <= TRANSPARENT_ENCODING;
        else if (w_rd_hit)
            readColor4 <= r_mem[{readY[YW-1:0], readX[XW-1:0]}];
        else
            readColor4 <= TRANSPARENT_ENCODING;
    end

endmodule
